// File: rtl/iter_div_axis.sv
// -----------------------------------------------------------------------------
// iter_div_axis
//
// Multi-cycle radix-2 restoring divider with stream-style operand and result
// channels. It serves div.w / mod.w / div.wu / mod.wu from the EXE stage. Build
// one instance with SIGNED=1 and one with SIGNED=0.
//
// Optional build macro:
//   DIV_FAST_PATH_EN - when defined, a zero divisor or |dividend| < |divisor|
//                      skips the iteration. The result is then valid one cycle
//                      after the second operand is captured. Results are
//                      bit-identical with and without the macro.
//
// Parameters:
//   DATA_W  operand width; quotient and remainder are each DATA_W bits
//   SIGNED  1 = two's-complement division, 0 = unsigned division
//
// Ports:
//   clk                     clock
//   resetn                  asynchronous, active-low reset
//   s_axis_divisor_tvalid   divisor offered
//   s_axis_divisor_tready   divisor slot empty, block can accept
//   s_axis_divisor_tdata    divisor
//   s_axis_dividend_tvalid  dividend offered
//   s_axis_dividend_tready  dividend slot empty, block can accept
//   s_axis_dividend_tdata   dividend
//   m_axis_dout_tvalid      result valid, one-cycle pulse, no back-pressure
//   m_axis_dout_tdata       {quotient, remainder}
//
// Handshake: an operand transfers on a rising clk edge where tvalid && tready.
// The two operand channels are independent and may complete in the same cycle
// or in different cycles, in either order. Once a slot holds data, its tready
// stays low until the division that uses it has finished. The result channel
// has no tready. m_axis_dout_tvalid is high for exactly one cycle, and the
// consumer must sample it in that cycle. m_axis_dout_tdata holds its value
// until the next result is produced.
// -----------------------------------------------------------------------------
module iter_div_axis #(
    parameter int DATA_W = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                s_axis_divisor_tvalid,
    output logic                s_axis_divisor_tready,
    input  logic [DATA_W-1:0]   s_axis_divisor_tdata,
    input  logic                s_axis_dividend_tvalid,
    output logic                s_axis_dividend_tready,
    input  logic [DATA_W-1:0]   s_axis_dividend_tdata,
    output logic                m_axis_dout_tvalid,
    output logic [2*DATA_W-1:0] m_axis_dout_tdata
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_e               state_q,    state_d;
    logic                 rdy_en_q,   rdy_en_d;     // low until first edge after reset
    logic                 dvs_full_q, dvs_full_d;
    logic                 dvd_full_q, dvd_full_d;
    logic [DATA_W-1:0]    dvs_raw_q,  dvs_raw_d;    // operands exactly as received
    logic [DATA_W-1:0]    dvd_raw_q,  dvd_raw_d;
    logic [DATA_W-1:0]    dvs_abs_q,  dvs_abs_d;    // divisor magnitude
    logic [DATA_W-1:0]    quo_q,      quo_d;        // dividend bits out, quotient bits in
    logic [DATA_W-1:0]    rem_q,      rem_d;        // partial remainder
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 tvalid_q,   tvalid_d;
    logic [2*DATA_W-1:0]  tdata_q,    tdata_d;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        // The most negative value maps to itself. As an unsigned magnitude it
        // is still correct: 0x80000000 reads as 2^31.
        if (SIGNED && x[DATA_W-1]) begin
            return -x;
        end
        return x;
    endfunction

    // Turns the unsigned magnitudes into the architectural result. A zero
    // divisor bypasses the sign rules. It always gives an all-ones quotient
    // and the raw dividend as the remainder.
    function automatic logic [2*DATA_W-1:0] fix_up(
        input logic [DATA_W-1:0] q_mag,
        input logic [DATA_W-1:0] r_mag,
        input logic [DATA_W-1:0] dvd_raw,
        input logic [DATA_W-1:0] dvs_raw
    );
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] r;
        if (dvs_raw == '0) begin
            return {{DATA_W{1'b1}}, dvd_raw};
        end
        q = q_mag;
        r = r_mag;
        if (SIGNED && (dvd_raw[DATA_W-1] ^ dvs_raw[DATA_W-1])) begin
            q = -q_mag;
        end
        if (SIGNED && dvd_raw[DATA_W-1]) begin
            r = -r_mag;
        end
        return {q, r};
    endfunction

    // -------------------------------------------------------------------------
    // Operand channels
    // -------------------------------------------------------------------------
    logic              dvs_fire;
    logic              dvd_fire;
    logic              both_now;
    logic [DATA_W-1:0] dvs_cur;
    logic [DATA_W-1:0] dvd_cur;

    assign s_axis_divisor_tready  = rdy_en_q && (state_q == ST_IDLE) && !dvs_full_q;
    assign s_axis_dividend_tready = rdy_en_q && (state_q == ST_IDLE) && !dvd_full_q;

    assign dvs_fire = s_axis_divisor_tvalid  && s_axis_divisor_tready;
    assign dvd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;

    // If a slot fills on this edge, its value comes straight from the bus.
    assign dvs_cur  = dvs_full_q ? dvs_raw_q : s_axis_divisor_tdata;
    assign dvd_cur  = dvd_full_q ? dvd_raw_q : s_axis_dividend_tdata;
    assign both_now = (dvs_full_q || dvs_fire) && (dvd_full_q || dvd_fire);

    // -------------------------------------------------------------------------
    // One restoring shift-subtract step
    // -------------------------------------------------------------------------
    logic [DATA_W:0]   shifted;
    logic              step_ge;
    logic [DATA_W-1:0] rem_step;
    logic [DATA_W-1:0] quo_step;

    always_comb begin
        shifted  = {rem_q, quo_q[DATA_W-1]};
        step_ge  = (shifted >= {1'b0, dvs_abs_q});
        // After a subtract the remainder is below the divisor, so it fits in
        // DATA_W bits. The subtraction can therefore be done modulo 2^DATA_W.
        rem_step = step_ge ? (shifted[DATA_W-1:0] - dvs_abs_q) : shifted[DATA_W-1:0];
        quo_step = {quo_q[DATA_W-2:0], step_ge};
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rdy_en_d   = 1'b1;
        dvs_full_d = dvs_full_q;
        dvd_full_d = dvd_full_q;
        dvs_raw_d  = dvs_raw_q;
        dvd_raw_d  = dvd_raw_q;
        dvs_abs_d  = dvs_abs_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        tvalid_d   = 1'b0;
        tdata_d    = tdata_q;

        case (state_q)
            ST_IDLE: begin
                if (dvs_fire) begin
                    dvs_full_d = 1'b1;
                    dvs_raw_d  = s_axis_divisor_tdata;
                end
                if (dvd_fire) begin
                    dvd_full_d = 1'b1;
                    dvd_raw_d  = s_axis_dividend_tdata;
                end
                if (both_now) begin
                    dvs_abs_d = abs_val(dvs_cur);
                    quo_d     = abs_val(dvd_cur);
                    rem_d     = '0;
                    cnt_d     = CNT_W'(DATA_W);
                    state_d   = ST_CALC;
`ifdef DIV_FAST_PATH_EN
                    // These results are already known, so skip iterating.
                    if ((dvs_cur == '0) || (abs_val(dvd_cur) < abs_val(dvs_cur))) begin
                        cnt_d    = '0;
                        tvalid_d = 1'b1;
                        tdata_d  = fix_up('0, abs_val(dvd_cur), dvd_cur, dvs_cur);
                        state_d  = ST_DONE;
                    end
`endif
                end
            end

            ST_CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - 1'b1;
                // The last step feeds the sign fix-up and the output register
                // directly, so the result is stable for the whole DONE cycle.
                if (cnt_q == CNT_W'(1)) begin
                    tvalid_d = 1'b1;
                    tdata_d  = fix_up(quo_step, rem_step, dvd_raw_q, dvs_raw_q);
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                dvs_full_d = 1'b0;
                dvd_full_d = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            rdy_en_q   <= 1'b0;
            dvs_full_q <= 1'b0;
            dvd_full_q <= 1'b0;
            dvs_raw_q  <= '0;
            dvd_raw_q  <= '0;
            dvs_abs_q  <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= rdy_en_d;
            dvs_full_q <= dvs_full_d;
            dvd_full_q <= dvd_full_d;
            dvs_raw_q  <= dvs_raw_d;
            dvd_raw_q  <= dvd_raw_d;
            dvs_abs_q  <= dvs_abs_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
        end
    end

    assign m_axis_dout_tvalid = tvalid_q;
    assign m_axis_dout_tdata  = tdata_q;

endmodule

// File: tb/tb_iter_div_axis.sv
// -----------------------------------------------------------------------------
// tb_iter_div_axis
//
// Directed bench for iter_div_axis. Index 1 of each signal pair drives the
// SIGNED=1 instance; index 0 drives the SIGNED=0 instance. Every expected
// value below is worked out by hand from the division definition.
// -----------------------------------------------------------------------------
module tb_iter_div_axis;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

`ifdef DIV_FAST_PATH_EN
    localparam int FP_LAT = 1;
`else
    localparam int FP_LAT = 33;
`endif

    logic [1:0]        dvs_valid, dvs_ready, dvd_valid, dvd_ready, out_valid;
    logic [1:0][31:0]  dvs_data, dvd_data;
    logic [1:0][63:0]  out_data;

    int tests = 0;
    int fails = 0;

    iter_div_axis #(.DATA_W(32), .SIGNED(1'b1)) u_div_s (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_divisor_tvalid  (dvs_valid[1]),
        .s_axis_divisor_tready  (dvs_ready[1]),
        .s_axis_divisor_tdata   (dvs_data[1]),
        .s_axis_dividend_tvalid (dvd_valid[1]),
        .s_axis_dividend_tready (dvd_ready[1]),
        .s_axis_dividend_tdata  (dvd_data[1]),
        .m_axis_dout_tvalid     (out_valid[1]),
        .m_axis_dout_tdata      (out_data[1])
    );

    iter_div_axis #(.DATA_W(32), .SIGNED(1'b0)) u_div_u (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_divisor_tvalid  (dvs_valid[0]),
        .s_axis_divisor_tready  (dvs_ready[0]),
        .s_axis_divisor_tdata   (dvs_data[0]),
        .s_axis_dividend_tvalid (dvd_valid[0]),
        .s_axis_dividend_tready (dvd_ready[0]),
        .s_axis_dividend_tdata  (dvd_data[0]),
        .m_axis_dout_tvalid     (out_valid[0]),
        .m_axis_dout_tdata      (out_data[0])
    );

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called in cycle 1 after capture. Returns the cycle in which tvalid is
    // seen, or 80 if no pulse arrives in time.
    task automatic wait_result(input int sel, output int lat);
        lat = 1;
        while (!out_valid[sel] && lat < 80) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Offers both operands in the same cycle, then checks latency, data and
    // the return to IDLE.
    task automatic run_div(input string name, input int sel,
                           input logic [31:0] dvd, input logic [31:0] dvs,
                           input logic [63:0] exp_d, input int exp_lat);
        int lat;
        @(negedge clk);
        dvd_valid[sel] = 1'b1;
        dvd_data[sel]  = dvd;
        dvs_valid[sel] = 1'b1;
        dvs_data[sel]  = dvs;
        check({name, " rdy"}, {62'd0, dvd_ready[sel], dvs_ready[sel]}, 64'd3);
        @(negedge clk);
        dvd_valid[sel] = 1'b0;
        dvs_valid[sel] = 1'b0;
        wait_result(sel, lat);
        check({name, " lat"}, 64'(lat), 64'(exp_lat));
        check({name, " data"}, out_data[sel], exp_d);
        @(negedge clk);
        check({name, " idle"}, {61'd0, out_valid[sel], dvd_ready[sel], dvs_ready[sel]}, 64'd3);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int cyc;
        logic bad;

        resetn    = 1'b0;
        dvs_valid = '0;
        dvd_valid = '0;
        dvs_data  = '0;
        dvd_data  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset rdy", {60'd0, dvd_ready, dvs_ready}, 64'd0);
        check("reset tvalid", {62'd0, out_valid}, 64'd0);
        check("reset tdata s", out_data[1], 64'd0);
        check("reset tdata u", out_data[0], 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post reset rdy", {60'd0, dvd_ready, dvs_ready}, 64'hF);

        // Main function
        run_div("u 100/7", 0, 32'd100, 32'd7, {32'h0000000E, 32'h00000002}, 33);
        run_div("u ffffffff/16", 0, 32'hFFFFFFFF, 32'h10, {32'h0FFFFFFF, 32'h0000000F}, 33);
        run_div("s 100/7", 1, 32'd100, 32'd7, {32'h0000000E, 32'h00000002}, 33);
        run_div("s -100/-7", 1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'h0000000E, 32'hFFFFFFFE}, 33);
        run_div("s 7/-2", 1, 32'd7, 32'hFFFFFFFE, {32'hFFFFFFFD, 32'h00000001}, 33);

        // Dividend -7 captured three cycles before divisor 2
        @(negedge clk);
        dvd_valid[1] = 1'b1;
        dvd_data[1]  = 32'hFFFFFFF9;
        check("split dvd rdy", {63'd0, dvd_ready[1]}, 64'd1);
        @(negedge clk);
        dvd_valid[1] = 1'b0;
        check("split slot", {62'd0, dvd_ready[1], dvs_ready[1]}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        dvs_valid[1] = 1'b1;
        dvs_data[1]  = 32'd2;
        @(negedge clk);
        dvs_valid[1] = 1'b0;
        wait_result(1, lat);
        check("split lat", 64'(lat), 64'd33);
        check("split data", out_data[1], {32'hFFFFFFFD, 32'hFFFFFFFF});
        @(negedge clk);

        // Boundary cases
        run_div("s min/-1", 1, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h00000000}, 33);
        run_div("u 5/0", 0, 32'd5, 32'd0, {32'hFFFFFFFF, 32'h00000005}, FP_LAT);
        run_div("s -5/0", 1, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFF, 32'hFFFFFFFB}, FP_LAT);
        run_div("u 3/9", 0, 32'd3, 32'd9, {32'h00000000, 32'h00000003}, FP_LAT);
        run_div("s -3/9", 1, 32'hFFFFFFFD, 32'd9, {32'h00000000, 32'hFFFFFFFD}, FP_LAT);

        // Back-to-back: second pair held valid from the cycle after the first capture
        @(negedge clk);
        dvd_valid[0] = 1'b1;
        dvd_data[0]  = 32'd1000;
        dvs_valid[0] = 1'b1;
        dvs_data[0]  = 32'd10;
        @(negedge clk);
        dvd_data[0] = 32'd77;
        dvs_data[0] = 32'd5;
        bad = 1'b0;
        cyc = 1;
        while (!out_valid[0] && cyc < 80) begin
            if (dvd_ready[0] || dvs_ready[0]) bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("b2b holdoff", {63'd0, bad}, 64'd0);
        check("b2b lat1", 64'(cyc), 64'd33);
        check("b2b data1", out_data[0], {32'h00000064, 32'h00000000});
        check("b2b done rdy", {62'd0, dvd_ready[0], dvs_ready[0]}, 64'd0);
        @(negedge clk);
        check("b2b idle rdy", {61'd0, out_valid[0], dvd_ready[0], dvs_ready[0]}, 64'd3);
        @(negedge clk);
        dvd_valid[0] = 1'b0;
        dvs_valid[0] = 1'b0;
        wait_result(0, lat);
        check("b2b gap", 64'(34 + lat - 33), 64'd34);
        check("b2b data2", out_data[0], {32'h0000000F, 32'h00000002});
        @(negedge clk);

        // Reset in CALC cycle 10
        @(negedge clk);
        dvd_valid[1] = 1'b1;
        dvd_data[1]  = 32'd1000;
        dvs_valid[1] = 1'b1;
        dvs_data[1]  = 32'd7;
        @(negedge clk);
        dvd_valid[1] = 1'b0;
        dvs_valid[1] = 1'b0;
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("abort rdy", {60'd0, dvd_ready, dvs_ready}, 64'd0);
        check("abort tvalid", {62'd0, out_valid}, 64'd0);
        check("abort tdata s", out_data[1], 64'd0);
        check("abort tdata u", out_data[0], 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("abort release rdy", {60'd0, dvd_ready, dvs_ready}, 64'hF);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid[1]) bad = 1'b1;
            @(negedge clk);
        end
        check("abort no pulse", {63'd0, bad}, 64'd0);
        run_div("s 1000/7 after abort", 1, 32'd1000, 32'd7, {32'h0000008E, 32'h00000006}, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
